// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter for toggle-handshake requests from foreign clock domains.
// Requests are double-flop synchronized; completion returns to the requester as an ack toggle.
module sync_req_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic [NUM_REQ-1:0] req_toggle_i,
  output logic [NUM_REQ-1:0] ack_toggle_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               start_o,
  input  logic               done_i,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast =
      (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax   = '1;
  localparam logic [IdxW-1:0] LastInit = IdxW'(NUM_REQ - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  // Synchronizer flops; kept adjacent and free of logic between stages.
  (* async_reg = "true" *) logic [NUM_REQ-1:0] sync_q0_q;
  (* async_reg = "true" *) logic [NUM_REQ-1:0] sync_q1_q;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [IdxW-1:0]     win_q, win_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;

  logic [NUM_REQ-1:0]  pending;
  logic                sel_valid;
  logic [IdxW-1:0]     sel_idx;
  logic [IdxW-1:0]     cand;
  logic                to_hit;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q0_q <= '0;
      sync_q1_q <= '0;
    end else begin
      sync_q0_q <= req_toggle_i;
      sync_q1_q <= sync_q0_q;
    end
  end

  assign pending = sync_q1_q ^ ack_q;

  // Search starts just after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IdxW'((32'(last_q) + off) % NUM_REQ);
      if (!sel_valid && pending[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    ack_d     = ack_q;
    grant_d   = grant_q;
    start_d   = 1'b0;
    busy_d    = busy_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (sel_valid) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          win_d            = sel_idx;
          start_d          = 1'b1;
          busy_d           = 1'b1;
          cnt_d            = '0;
          state_d          = StWait;
        end
      end
      StWait: begin
        // done_i takes priority over a simultaneous timeout.
        if (done_i || to_hit) begin
          ack_d[win_q] = ~ack_q[win_q];
          last_d       = win_q;
          grant_d      = '0;
          busy_d       = 1'b0;
          timeout_d    = ~done_i;
          state_d      = StIdle;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= StIdle;
      last_q    <= LastInit;
      win_q     <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      grant_q   <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign ack_toggle_o = ack_q;
  assign grant_o      = grant_q;
  assign start_o      = start_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;

endmodule
